add_arb: RTL and testbench

ADD_ARB -- requirements
Module: add_arb

---
 rtl/add_pkg.sv | 19 +
 rtl/add_arb_rr_arb2.sv | 24 ++
 rtl/add_arb.sv | 146 ++++++++++++++
 tb/tb_add_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and default sizes for the arbitrated adder front end.
// Both the top level and the testbench import this package.
package add_pkg;

    // Default operand/result width and default latency of the external adder.
    localparam int DW_DEFAULT      = 32;
    localparam int ADD_LAT_DEFAULT = 1;

    // The latency counter must hold the largest legal latency, which is 15.
    localparam int CNT_W = 4;

    // Operation sequencing: accept operands, wait for the adder, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/add_arb_rr_arb2.sv
// Two-way round-robin arbiter.
// The ptr input names the requester that wins when both ask at once.
// A lone requester is always granted, whatever ptr says.
// No grant is issued while en is low.
module rr_arb2 (
    input  logic       en,
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Pick at most one requester: the preferred one on a tie, otherwise whoever is asking.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/add_arb.sv
// Arbitrated front end for one shared external adder.
// Two requesters offer operand pairs, and one operation is in flight at a time.
// The adder result is captured once the adder latency has elapsed.
// It is then presented to the requester that issued it until that requester takes it.
// Requesters are served round-robin, so neither can starve the other.
module add_arb
    import add_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int ADD_LAT = ADD_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,

    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp_sum,

    output logic [DW-1:0] add_in1,
    output logic [DW-1:0] add_in2,
    input  logic [DW-1:0] add_out,

    output logic          busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ADD_LAT);

    state_t           state_q;
    logic             ptr_q;
    logic             sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    opa_q;
    logic [DW-1:0]    opb_q;
    logic [DW-1:0]    sum_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             busy_q;

    logic             arb_en;
    logic [1:0]       arb_req;
    logic [1:0]       gnt;
    logic             rsp_hs;

    // Only offer a grant in IDLE and never while reset is applied.
    // An accept during reset would be thrown away, so ready must stay low then.
    assign arb_en  = (state_q == IDLE) && !rst;
    assign arb_req = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .en  (arb_en),
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // The operand registers feed the adder directly.
    // They only change on an accept, so the adder inputs stay still for the whole operation.
    assign add_in1    = opa_q;
    assign add_in2    = opb_q;

    assign rsp_sum    = sum_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

    // A responder's ready counts only while its own valid is high.
    // A ready from the other side is ignored.
    assign rsp_hs = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

    // Operation sequencer.
    // It latches the granted operands and counts down the adder latency.
    // It captures the sum, holds it until the issuing requester takes it, then hands priority to the other requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            sel_q        <= 1'b0;
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            sum_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt[1]) begin
                        sel_q <= 1'b1;
                        opa_q <= req1_a;
                        opb_q <= req1_b;
                    end else if (gnt[0]) begin
                        sel_q <= 1'b0;
                        opa_q <= req0_a;
                        opb_q <= req0_b;
                    end
                    if (gnt != 2'b00) begin
                        cnt_q   <= LAT_LOAD;
                        state_q <= WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        sum_q        <= add_out;
                        state_q      <= RESP;
                        rsp0_valid_q <= !sel_q;
                        rsp1_valid_q <= sel_q;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        state_q      <= IDLE;
                        ptr_q        <= !sel_q;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_arb.sv
// Self-checking bench for add_arb.
// Four instances with adder latencies 1, 3, 4 and 15 share one set of request and response inputs.
// Instance 0 (latency 1) carries the functional tests, and all four are compared in the latency sweep and after a reset mid-operation.
// Each instance talks to its own behavioural adder that delays the sum by the instance latency.
module tb_add_arb;
    import add_pkg::*;

    localparam int NI = 4;

    typedef struct {
        int          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    typedef struct {
        int          who;
        logic [31:0] sum;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        rsp0_ready = 1'b1;
    logic        rsp1_ready = 1'b1;

    logic        r0r [NI];
    logic        r1r [NI];
    logic        s0v [NI];
    logic        s1v [NI];
    logic        bsy [NI];
    logic [31:0] sum [NI];
    logic [31:0] in1 [NI];
    logic [31:0] in2 [NI];
    logic [31:0] aout[NI];

    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;
    exp_t sbq[$];

    // Free-running clock and a cycle count used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    // One DUT per latency, each with an adder model.
    // The adder model shows the sum of its inputs as they were ADD_LAT-1 cycles earlier.
    // A result captured too early would therefore be stale.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 15;

        logic [31:0] hist [16];

        add_arb #(.DW(32), .ADD_LAT(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (req0_valid),
            .req0_ready (r0r[g]),
            .req0_a     (req0_a),
            .req0_b     (req0_b),
            .req1_valid (req1_valid),
            .req1_ready (r1r[g]),
            .req1_a     (req1_a),
            .req1_b     (req1_b),
            .rsp0_valid (s0v[g]),
            .rsp0_ready (rsp0_ready),
            .rsp1_valid (s1v[g]),
            .rsp1_ready (rsp1_ready),
            .rsp_sum    (sum[g]),
            .add_in1    (in1[g]),
            .add_in2    (in2[g]),
            .add_out    (aout[g]),
            .busy       (bsy[g])
        );

        // Delay line of past adder-input sums; entry k is the sum from k+1 cycles ago.
        always @(posedge clk) begin
            hist[0] <= in1[g] + in2[g];
            for (int k = 1; k < 16; k++) hist[k] <= hist[k-1];
        end

        if (L == 1) begin : g_comb
            assign aout[g] = in1[g] + in2[g];
        end else begin : g_dly
            assign aout[g] = hist[L-2];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic failCheck(input string name);
        nChecks++;
        $display("[TB] FAIL %s: got no event, want one within the cycle budget", name);
    endtask

    // Scoreboard for instance 0.
    // It pushes the bench-computed sum on every accept and pops and compares on every response handshake.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            sbq.delete();
        end else begin
            if (req0_valid && r0r[0]) begin
                e.who = 0;
                e.sum = req0_a + req0_b;
                sbq.push_back(e);
            end
            if (req1_valid && r1r[0]) begin
                e.who = 1;
                e.sum = req1_a + req1_b;
                sbq.push_back(e);
            end
            if ((s0v[0] && rsp0_ready) || (s1v[0] && rsp1_ready)) begin
                if (sbq.size() == 0) begin
                    failCheck("sb-unexpected-rsp");
                end else begin
                    e = sbq.pop_front();
                    checkOutput("sb-who", s1v[0] ? 32'd1 : 32'd0, 32'(e.who));
                    checkOutput("sb-sum", sum[0], e.sum);
                end
            end
        end
    end

    task automatic doReset(input int n);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one operand pair on one requester until it is accepted.
    // accCyc returns the cycle in which the handshake took place.
    task automatic applyStimulus(input int who, input logic [31:0] a, input logic [31:0] b,
                                 output int accCyc);
        bit got = 1'b0;
        accCyc = -1;
        @(negedge clk);
        if (who == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        for (int n = 0; n < 64 && !got; n++) begin
            #1;
            if ((who == 0) ? r0r[0] : r1r[0]) begin
                got = 1'b1;
                accCyc = cyc;
            end
            @(negedge clk);
        end
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        if (!got) failCheck($sformatf("req%0d-accept-timeout", who));
    endtask

    task automatic waitRsp(input int who, input int inst, input int maxc, output int rc);
        bit got = 1'b0;
        rc = -1;
        for (int n = 0; n < maxc && !got; n++) begin
            @(negedge clk);
            #1;
            if ((who == 0) ? s0v[inst] : s1v[inst]) begin
                got = 1'b1;
                rc = cyc;
            end
        end
        if (!got) failCheck($sformatf("rsp%0d-timeout", who));
    endtask

    // Issue one operation to every instance at once and check each one's sum and accept-to-response latency.
    task automatic sweepCheck(input int who, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        int acc;
        int seen[NI];
        applyStimulus(who, a, b, acc);
        for (int i = 0; i < NI; i++) seen[i] = -1;
        for (int n = 0; n < 24; n++) begin
            #1;
            for (int i = 0; i < NI; i++) begin
                if (seen[i] < 0 && ((who == 0) ? s0v[i] : s1v[i])) begin
                    seen[i] = cyc;
                    checkOutput($sformatf("sweep-sum-L%0d", latOf(i)), sum[i], exp);
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < NI; i++) begin
            if (seen[i] < 0) failCheck($sformatf("sweep-rsp-L%0d", latOf(i)));
            else checkOutput($sformatf("sweep-lat-L%0d", latOf(i)),
                             32'(seen[i] - acc), 32'(latOf(i) + 1));
        end
    endtask

    // Hard stop in case a wait outside the bounded loops ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   acc, rc, got;
        logic hold, anyv;

        vecs[0] = '{0, 32'd5,          32'd7,          32'd12};
        vecs[1] = '{1, 32'd10,         32'd20,         32'd30};
        vecs[2] = '{0, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001};
        vecs[3] = '{1, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000};
        vecs[4] = '{0, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789};
        vecs[5] = '{1, 32'hDEAD_0000,  32'h0000_BEEF,  32'hDEAD_BEEF};

        // Reset state, with a request already waiting while reset is held.
        rst = 1'b1;
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst-ready-held", 32'(r0r[0]), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst-busy",   32'(bsy[0]), 32'd0);
        checkOutput("rst-rspv",   32'({s0v[0], s1v[0]}), 32'd0);
        checkOutput("rst-addin1", in1[0], 32'd0);
        checkOutput("rst-addin2", in2[0], 32'd0);
        checkOutput("rst-sum",    sum[0], 32'd0);

        // Single operations from the table, each checked for latency, sum and the other responder staying quiet.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].who, vecs[v].a, vecs[v].b, acc);
            waitRsp(vecs[v].who, 0, 10, rc);
            checkOutput($sformatf("vec%0d-lat", v), 32'(rc - acc), 32'd2);
            checkOutput($sformatf("vec%0d-sum", v), sum[0], vecs[v].sum);
            checkOutput($sformatf("vec%0d-other", v),
                        32'((vecs[v].who == 0) ? s1v[0] : s0v[0]), 32'd0);
        end

        // Contention from reset: both requesters held valid, so grants must alternate 0,1,0,1.
        doReset(2);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd3;  req0_b = 32'd4;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int n = 0; n < 20 && got < 0; n++) begin
                #1;
                if (r0r[0] && r1r[0]) got = 2;
                else if (r0r[0])      got = 0;
                else if (r1r[0])      got = 1;
                if (got < 0) @(negedge clk);
            end
            checkOutput($sformatf("cont-grant%0d", k), 32'(got), 32'(k % 2));
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitRsp(1, 0, 10, rc);

        // Backpressure on responder 1 while requester 0 keeps asking.
        doReset(2);
        rsp1_ready = 1'b0;
        applyStimulus(1, 32'd100, 32'd23, acc);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
        waitRsp(1, 0, 10, rc);
        for (int k = 0; k < 5; k++) begin
            hold = s1v[0] && !s0v[0] && (sum[0] == 32'd123) && !r0r[0] && (in1[0] == 32'd100);
            checkOutput($sformatf("bp-hold%0d", k), 32'(hold), 32'd1);
            @(negedge clk);
            #1;
        end
        rsp1_ready = 1'b1;
        #1;
        checkOutput("bp-no-early-grant", 32'(r0r[0]), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("bp-grant-after-hs", 32'(r0r[0]), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        waitRsp(0, 0, 10, rc);

        // Latency sweep across all four instances.
        doReset(2);
        sweepCheck(0, 32'd40, 32'd2, 32'd42);

        // Reset while the instances are mid-operation; the in-flight result must vanish.
        doReset(2);
        applyStimulus(0, 32'd9, 32'd8, acc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("midrst-busy-L%0d", latOf(i)), 32'(bsy[i]), 32'd0);
            checkOutput($sformatf("midrst-rspv-L%0d", latOf(i)), 32'({s0v[i], s1v[i]}), 32'd0);
        end
        anyv = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NI; i++) anyv = anyv | s0v[i] | s1v[i] | bsy[i];
        end
        checkOutput("midrst-discard", 32'(anyv), 32'd0);
        sweepCheck(1, 32'h55, 32'hAA, 32'hFF);

        repeat (4) @(negedge clk);
        checkOutput("sb-drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
